// File: rtl/avg_seq_pkg.sv
// ============================================================================
//  avg_seq_pkg
//  Shared types and constants for the vector-generator state sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package avg_seq_pkg;

  // Field widths of the state PROM address {op_reg, halt_n, st}
  localparam int OP_W   = 3;
  localparam int ST_W   = 4;
  localparam int ADDR_W = OP_W + 1 + ST_W;

  // Opcode that drops halt_n and steers the PROM into its halt page
  localparam logic [OP_W-1:0] HALT_OP = 3'b111;

  // Bit positions of the three control strobes inside a PROM nibble
  localparam int STRB_IDX_0 = 0;
  localparam int STRB_IDX_1 = 1;
  localparam int STRB_IDX_2 = 2;
  localparam int STRB_W     = 3;

  // Bit of the PROM nibble that requests an opcode fetch
  localparam int FETCH_BIT = 3;

  // Sequencer phase
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ADDR  = 2'd1,
    PH_LATCH = 2'd2,
    PH_FETCH = 2'd3
  } phase_e;

  // PROM address assembly
  function automatic logic [ADDR_W-1:0] rom_address(
    input logic [OP_W-1:0] op,
    input logic            halt_n,
    input logic [ST_W-1:0] st
  );
    return {op, halt_n, st};
  endfunction

endpackage

`default_nettype wire

// File: rtl/avg_state_sequencer.sv
// ============================================================================
//  avg_state_sequencer
//  Drives the 256x4 state PROM: forms the address from opcode, halt line and
//  state, absorbs the one-cycle registered read, and turns each returned
//  nibble into next state, strobes and an opcode-fetch handshake.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module avg_state_sequencer
  import avg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic              op_valid_i,
  input  logic [OP_W-1:0]   op_code_i,
  output logic              op_ready_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_cs_o,
  input  logic [ST_W-1:0]   rom_dout_i,
  output logic [STRB_W-1:0] strb_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ST_W-1:0]   st_out_o
);

  phase_e              phase_q;
  logic [ST_W-1:0]     st_q;
  logic [OP_W-1:0]     op_reg_q;
  logic [STRB_W-1:0]   strb_q;
  logic                done_q;
  logic                halt_n;

  // halt_n follows op_reg directly, so a fetched HALT_OP hits the next address
  assign halt_n = (op_reg_q != HALT_OP);

  // Phase FSM with registered strobe and done pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      st_q     <= '0;
      op_reg_q <= '0;
      strb_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      strb_q <= '0;
      done_q <= 1'b0;
      case (phase_q)
        PH_IDLE: begin
          if (go_i) begin
            st_q     <= '0;
            op_reg_q <= '0;
            phase_q  <= PH_ADDR;
          end
        end
        PH_ADDR: begin
          phase_q <= PH_LATCH;
        end
        PH_LATCH: begin
          st_q   <= rom_dout_i;
          strb_q <= rom_dout_i[STRB_IDX_2:STRB_IDX_0];
          if ((rom_dout_i == '0) && !halt_n) begin
            phase_q <= PH_IDLE;
            done_q  <= 1'b1;
          end else if (rom_dout_i[FETCH_BIT]) begin
            phase_q <= PH_FETCH;
          end else begin
            phase_q <= PH_ADDR;
          end
        end
        PH_FETCH: begin
          if (op_valid_i) begin
            op_reg_q <= op_code_i;
            phase_q  <= PH_ADDR;
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  assign rom_addr_o = rom_address(op_reg_q, halt_n, st_q);
  assign rom_cs_o   = (phase_q == PH_ADDR) || (phase_q == PH_LATCH);
  assign op_ready_o = (phase_q == PH_FETCH);
  assign busy_o     = (phase_q != PH_IDLE);
  assign strb_o     = strb_q;
  assign done_o     = done_q;
  assign st_out_o   = st_q;

endmodule

`default_nettype wire

// File: tb/tb_avg_state_sequencer.sv
// ============================================================================
//  tb_avg_state_sequencer
//  Self-checking bench: PROM image, step-level reference model, per-cycle
//  compare, directed literal checks and randomized stimulus.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avg_state_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'b000;
  logic       op_ready;
  logic [7:0] rom_addr;
  logic       rom_cs;
  logic [3:0] rom_dout = 4'h0;
  logic [2:0] strb;
  logic       busy;
  logic       done;
  logic [3:0] st_out;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [3:0] rom [256];

  avg_state_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .go_i       (go),
    .op_valid_i (op_valid),
    .op_code_i  (op_code),
    .op_ready_o (op_ready),
    .rom_addr_o (rom_addr),
    .rom_cs_o   (rom_cs),
    .rom_dout_i (rom_dout),
    .strb_o     (strb),
    .busy_o     (busy),
    .done_o     (done),
    .st_out_o   (st_out)
  );

  always #5 clk = ~clk;

  // PROM image: fixed entries at the start-up path, halt page all zero
  initial begin
    for (int a = 0; a < 256; a++) begin
      if (a >= 8'hE0 && a <= 8'hEF) rom[a] = 4'h0;
      else                          rom[a] = 4'((a * 7 + 3) % 16);
    end
    rom[8'h10] = 4'hB;
    rom[8'h5B] = 4'h9;
  end

  // Registered PROM read: data appears the cycle after the address
  always @(posedge clk) begin
    if (rom_cs) rom_dout <= rom[rom_addr];
  end

  // Reference model, one PROM step = address cycle, data cycle, optional wait
  bit         m_idle = 1'b1;
  int         m_k = 0;        // 0: address cycle, 1: data cycle, 2: waiting for opcode
  int         m_st = 0;
  int         m_op = 0;
  int         m_strb = 0;
  bit         m_done = 1'b0;

  function automatic int model_addr();
    return m_op * 32 + ((m_op != 7) ? 16 : 0) + m_st;
  endfunction

  always @(posedge clk) begin
    int d;
    if (reset) begin
      m_idle = 1'b1; m_k = 0; m_st = 0; m_op = 0; m_strb = 0; m_done = 1'b0;
    end else begin
      m_strb = 0;
      m_done = 1'b0;
      if (m_idle) begin
        if (go) begin
          m_idle = 1'b0; m_k = 0; m_st = 0; m_op = 0;
        end
      end else if (m_k == 0) begin
        m_k = 1;
      end else if (m_k == 1) begin
        d      = int'(rom[model_addr()]);
        m_st   = d;
        m_strb = d % 8;
        if (d == 0 && m_op == 7) begin
          m_idle = 1'b1; m_done = 1'b1;
        end else if (d >= 8) m_k = 2;
        else                 m_k = 0;
      end else begin
        if (op_valid) begin
          m_op = int'(op_code); m_k = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_busy",     32'(busy),     32'(!m_idle));
      check("m_rom_cs",   32'(rom_cs),   32'(!m_idle && m_k < 2));
      check("m_op_ready", 32'(op_ready), 32'(!m_idle && m_k == 2));
      check("m_rom_addr", 32'(rom_addr), 32'(model_addr()));
      check("m_strb",     32'(strb),     32'(m_strb));
      check("m_done",     32'(done),     32'(m_done));
      check("m_st",       32'(st_out),   32'(m_st));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset hold
    reset = 1'b1;
    tick(); cmp_en = 1'b1;
    tick(); tick();
    check("rst_addr",  32'(rom_addr), 32'h10);
    check("rst_busy",  32'(busy),     32'h0);
    check("rst_done",  32'(done),     32'h0);
    check("rst_strb",  32'(strb),     32'h0);
    check("rst_ready", 32'(op_ready), 32'h0);
    check("rst_st",    32'(st_out),   32'h0);
    check("rst_cs",    32'(rom_cs),   32'h0);
    reset = 1'b0;
    tick();

    // Start and first fetch
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_addr_cs", 32'(rom_cs),   32'h1);
    check("go_addr",    32'(rom_addr), 32'h10);
    tick();
    check("go_latch_cs", 32'(rom_cs), 32'h1);
    tick();
    check("go_st",    32'(st_out),   32'hB);
    check("go_strb",  32'(strb),     32'h3);
    check("go_ready", 32'(op_ready), 32'h1);

    // Fetch stall
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_addr",  32'(rom_addr), 32'h1B);
      check("stall_ready", 32'(op_ready), 32'h1);
      check("stall_strb",  32'(strb),     32'h0);
    end
    op_valid = 1'b1; op_code = 3'b010;
    tick();
    op_valid = 1'b0;
    check("fetch_addr", 32'(rom_addr), 32'h5B);

    // Halt completion
    tick(); tick();
    check("pre_halt_st", 32'(st_out), 32'h9);
    op_valid = 1'b1; op_code = 3'b111;
    tick();
    op_valid = 1'b0;
    check("halt_addr", 32'(rom_addr), 32'hE9);
    tick(); tick();
    check("halt_done",  32'(done),     32'h1);
    check("halt_st",    32'(st_out),   32'h0);
    check("halt_busy",  32'(busy),     32'h0);
    check("halt_ready", 32'(op_ready), 32'h0);
    tick();
    check("halt_done_end", 32'(done),     32'h0);
    check("halt_ready2",   32'(op_ready), 32'h0);

    // Reset during the data cycle
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    check("mid_latch_cs", 32'(rom_cs), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_strb", 32'(strb),   32'h0);
    check("mid_st",   32'(st_out), 32'h0);
    check("mid_busy", 32'(busy),   32'h0);
    check("mid_cs",   32'(rom_cs), 32'h0);
    tick();
    check("mid_strb2", 32'(strb), 32'h0);
    check("mid_done2", 32'(done), 32'h0);

    // Randomized traffic, including go/op_valid outside their phases
    for (int i = 0; i < 4000; i++) begin
      go       = ($urandom_range(0, 7) == 0);
      op_valid = ($urandom_range(0, 2) == 0);
      op_code  = 3'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0; go = 1'b0; op_valid = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
